// File: rtl/dc_wr_fifo_pkg.sv
// Shared definitions for the store buffer: size encodings, line geometry, entry layout.
package dc_wr_fifo_pkg;

    localparam logic [1:0] SZ_1B = 2'd0;
    localparam logic [1:0] SZ_2B = 2'd1;
    localparam logic [1:0] SZ_4B = 2'd2;
    localparam logic [1:0] SZ_8B = 2'd3;

    localparam int LINE_OFF_W = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [63:0] data;
        logic [1:0]  size;
    } st_entry_t;

    // Byte offset of the last byte touched by an access of this size.
    function automatic logic [31:0] size_to_last_off(input logic [1:0] size);
        return (32'd1 << size) - 32'd1;
    endfunction

endpackage

// File: rtl/dc_wr_fifo_line_cmp.sv
// Line-granular overlap test between one store and one load.
// Each access touches at most two lines; any shared line is a hit.
module wr_fifo_line_cmp
    import dc_wr_fifo_pkg::*;
(
    input  logic [31:0] st_addr,
    input  logic [1:0]  st_size,
    input  logic        st_valid,
    input  logic [31:0] ld_addr,
    input  logic [1:0]  ld_size,
    output logic        hit
);

    logic [31:0]            st_end;
    logic [31:0]            ld_end;
    logic [31-LINE_OFF_W:0] st_l0, st_l1, ld_l0, ld_l1;

    // Last-byte address wraps modulo 2^32; carry-out deliberately dropped.
    assign st_end = st_addr + size_to_last_off(st_size);
    assign ld_end = ld_addr + size_to_last_off(ld_size);

    assign st_l0 = st_addr[31:LINE_OFF_W];
    assign st_l1 = st_end[31:LINE_OFF_W];
    assign ld_l0 = ld_addr[31:LINE_OFF_W];
    assign ld_l1 = ld_end[31:LINE_OFF_W];

    assign hit = st_valid & ((st_l0 == ld_l0) | (st_l0 == ld_l1) |
                             (st_l1 == ld_l0) | (st_l1 == ld_l1));

endmodule

// File: rtl/dc_wr_fifo.sv
// Store buffer between write-back and the dcache write port, with load line-conflict detect.
module dc_wr_fifo
    import dc_wr_fifo_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_st_valid,
    input  logic [31:0] wb_st_addr,
    input  logic [63:0] wb_st_data,
    input  logic [1:0]  wb_st_size,
    output logic [31:0] mem_wr_addr,
    output logic [63:0] mem_wr_data,
    output logic [1:0]  mem_wr_size,
    output logic        wr_fifo_empty,
    output logic        wr_fifo_to_be_full,
    input  logic        mem_wr_done,
    input  logic        v_mem_read,
    input  logic [31:0] ro_rd_addr,
    input  logic [1:0]  ro_rd_size,
    output logic        mem_conflict,
    output logic        wr_fifo_ovf
);

    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];
    localparam logic [PTR_W:0] TBF_CNT  = FULL_CNT - 1'b1;

    st_entry_t        entry_q [DEPTH];
    logic [DEPTH-1:0] entry_valid;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic             push;
    logic             pop;
    logic [DEPTH:0]   hits;

    // A pop in the same cycle frees a slot, so a push into a full buffer is still accepted.
    assign pop  = mem_wr_done & (count != '0);
    assign push = wb_st_valid & ((count < FULL_CNT) | mem_wr_done);

    // Pointers, occupancy, per-entry valid bits and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            entry_valid <= '0;
            wr_fifo_ovf <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr              <= rd_ptr + PTR_W'(1);
                entry_valid[rd_ptr] <= 1'b0;
            end
            // When full with push+pop both pointers alias; the push must win the valid bit.
            if (push) begin
                wr_ptr              <= wr_ptr + PTR_W'(1);
                entry_valid[wr_ptr] <= 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wb_st_valid && !push) begin
                wr_fifo_ovf <= 1'b1;
            end
        end
    end

    // Entry payload storage; not reset, the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (push) begin
            entry_q[wr_ptr] <= '{addr: wb_st_addr, data: wb_st_data, size: wb_st_size};
        end
    end

    assign wr_fifo_empty      = (count == '0);
    assign wr_fifo_to_be_full = (count >= TBF_CNT);

    // Head presentation; zeroed while empty so stale storage never leaks out.
    always_comb begin
        mem_wr_addr = '0;
        mem_wr_data = '0;
        mem_wr_size = '0;
        if (!wr_fifo_empty) begin
            mem_wr_addr = entry_q[rd_ptr].addr;
            mem_wr_data = entry_q[rd_ptr].data;
            mem_wr_size = entry_q[rd_ptr].size;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent_cmp
        wr_fifo_line_cmp u_cmp (
            .st_addr  (entry_q[i].addr),
            .st_size  (entry_q[i].size),
            .st_valid (entry_valid[i]),
            .ld_addr  (ro_rd_addr),
            .ld_size  (ro_rd_size),
            .hit      (hits[i])
        );
    end

    // The store arriving this cycle is checked even if it ends up dropped: conservative.
    wr_fifo_line_cmp u_cmp_in (
        .st_addr  (wb_st_addr),
        .st_size  (wb_st_size),
        .st_valid (wb_st_valid),
        .ld_addr  (ro_rd_addr),
        .ld_size  (ro_rd_size),
        .hit      (hits[DEPTH])
    );

    assign mem_conflict = v_mem_read & (|hits);

endmodule

// File: tb/tb_dc_wr_fifo.sv
// Self-checking bench for dc_wr_fifo: directed scenarios plus randomized traffic vs a queue model.
module tb_dc_wr_fifo;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_st_valid = 1'b0;
    logic [31:0] wb_st_addr = '0;
    logic [63:0] wb_st_data = '0;
    logic [1:0]  wb_st_size = '0;
    logic [31:0] mem_wr_addr;
    logic [63:0] mem_wr_data;
    logic [1:0]  mem_wr_size;
    logic        wr_fifo_empty;
    logic        wr_fifo_to_be_full;
    logic        mem_wr_done = 1'b0;
    logic        v_mem_read = 1'b0;
    logic [31:0] ro_rd_addr = '0;
    logic [1:0]  ro_rd_size = '0;
    logic        mem_conflict;
    logic        wr_fifo_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
        logic [1:0]  size;
    } ent_t;

    ent_t q[$];
    bit   m_ovf;

    dc_wr_fifo #(.DEPTH(4), .PTR_W(2)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .wb_st_valid        (wb_st_valid),
        .wb_st_addr         (wb_st_addr),
        .wb_st_data         (wb_st_data),
        .wb_st_size         (wb_st_size),
        .mem_wr_addr        (mem_wr_addr),
        .mem_wr_data        (mem_wr_data),
        .mem_wr_size        (mem_wr_size),
        .wr_fifo_empty      (wr_fifo_empty),
        .wr_fifo_to_be_full (wr_fifo_to_be_full),
        .mem_wr_done        (mem_wr_done),
        .v_mem_read         (v_mem_read),
        .ro_rd_addr         (ro_rd_addr),
        .ro_rd_size         (ro_rd_size),
        .mem_conflict       (mem_conflict),
        .wr_fifo_ovf        (wr_fifo_ovf)
    );

    always #5 clk = ~clk;

    // Two accesses conflict if any line either touches is shared (lines = byte addr / 16).
    function automatic bit lines_hit(logic [31:0] sa, logic [1:0] ss, logic [31:0] la, logic [1:0] ls);
        logic [31:0] s_first, s_last, l_first, l_last;
        s_first = sa / 16;
        s_last  = (sa + (32'd1 << ss) - 32'd1) / 16;
        l_first = la / 16;
        l_last  = (la + (32'd1 << ls) - 32'd1) / 16;
        return (s_first == l_first) || (s_first == l_last) || (s_last == l_first) || (s_last == l_last);
    endfunction

    function automatic bit model_conflict();
        bit c = 0;
        if (!v_mem_read) return 0;
        foreach (q[i]) c |= lines_hit(q[i].addr, q[i].size, ro_rd_addr, ro_rd_size);
        if (wb_st_valid) c |= lines_hit(wb_st_addr, wb_st_size, ro_rd_addr, ro_rd_size);
        return c;
    endfunction

    task automatic set_in(bit push, logic [31:0] a, logic [63:0] d, logic [1:0] s, bit done,
                          bit vrd, logic [31:0] ra, logic [1:0] rs);
        wb_st_valid = push;
        wb_st_addr  = a;
        wb_st_data  = d;
        wb_st_size  = s;
        mem_wr_done = done;
        v_mem_read  = vrd;
        ro_rd_addr  = ra;
        ro_rd_size  = rs;
    endtask

    // Advance one clock and update the model from the inputs presented for that edge.
    task automatic tick();
        bit do_pop, do_push;
        ent_t e;
        do_pop  = mem_wr_done && (q.size() > 0);
        do_push = wb_st_valid && (q.size() < DEPTH || mem_wr_done);
        e = '{addr: wb_st_addr, data: wb_st_data, size: wb_st_size};
        @(posedge clk);
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(e);
        if (wb_st_valid && !do_push) m_ovf = 1;
        #1;
        set_in(0, '0, '0, '0, 0, 0, '0, '0);
    endtask

    task automatic do_reset();
        set_in(0, '0, '0, '0, 0, 0, '0, '0);
        @(negedge clk);
        rst_n = 1'b0;
        q.delete();
        m_ovf = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        set_in(0, '0, '0, '0, 0, 1, 32'h0, 2'd0);
        #1;
        n_checks++; if (wr_fifo_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %0b want 1", wr_fifo_empty); end
        n_checks++; if (wr_fifo_to_be_full !== 1'b0) begin n_fail++; $display("FAIL reset_tbf: got %0b want 0", wr_fifo_to_be_full); end
        n_checks++; if (wr_fifo_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %0b want 0", wr_fifo_ovf); end
        n_checks++; if (mem_conflict !== 1'b0) begin n_fail++; $display("FAIL reset_conflict: got %0b want 0", mem_conflict); end
        n_checks++; if ({mem_wr_addr, mem_wr_data, mem_wr_size} !== 98'd0) begin n_fail++; $display("FAIL reset_head: got %h/%h/%0d want 0", mem_wr_addr, mem_wr_data, mem_wr_size); end
        set_in(0, '0, '0, '0, 0, 0, '0, '0);
    endtask

    task automatic test_first_push();
        do_reset();
        set_in(1, 32'h1000, 64'hAA, 2'd0, 0, 0, '0, '0);
        #1;
        n_checks++; if (wr_fifo_empty !== 1'b1) begin n_fail++; $display("FAIL push_no_bypass_empty: got %0b want 1", wr_fifo_empty); end
        n_checks++; if (mem_wr_addr !== 32'h0) begin n_fail++; $display("FAIL push_no_bypass_addr: got %h want 0", mem_wr_addr); end
        tick();
        n_checks++; if (wr_fifo_empty !== 1'b0) begin n_fail++; $display("FAIL push_empty: got %0b want 0", wr_fifo_empty); end
        n_checks++; if (mem_wr_addr !== 32'h1000) begin n_fail++; $display("FAIL push_addr: got %h want 1000", mem_wr_addr); end
        n_checks++; if (mem_wr_data !== 64'hAA) begin n_fail++; $display("FAIL push_data: got %h want aa", mem_wr_data); end
        n_checks++; if (mem_wr_size !== 2'd0) begin n_fail++; $display("FAIL push_size: got %0d want 0", mem_wr_size); end
    endtask

    task automatic test_fill_ovf();
        logic [2:0] exp_tbf;
        do_reset();
        exp_tbf = 3'b100;
        for (int i = 0; i < 3; i++) begin
            set_in(1, 32'h100 * (i + 1), 64'(i + 1), 2'd2, 0, 0, '0, '0);
            tick();
            n_checks++; if (wr_fifo_to_be_full !== exp_tbf[i]) begin n_fail++; $display("FAIL fill_tbf_%0d: got %0b want %0b", i, wr_fifo_to_be_full, exp_tbf[i]); end
        end
        set_in(1, 32'h400, 64'h4, 2'd2, 0, 0, '0, '0);
        tick();
        n_checks++; if (wr_fifo_to_be_full !== 1'b1) begin n_fail++; $display("FAIL full_tbf: got %0b want 1", wr_fifo_to_be_full); end
        n_checks++; if (wr_fifo_ovf !== 1'b0) begin n_fail++; $display("FAIL full_ovf: got %0b want 0", wr_fifo_ovf); end
        set_in(1, 32'h500, 64'h5, 2'd2, 0, 0, '0, '0);
        tick();
        n_checks++; if (wr_fifo_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %0b want 1", wr_fifo_ovf); end
        n_checks++; if (mem_wr_addr !== 32'h100) begin n_fail++; $display("FAIL ovf_head: got %h want 100", mem_wr_addr); end
        tick();
        n_checks++; if (wr_fifo_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %0b want 1", wr_fifo_ovf); end
        // Drain: the dropped store must not appear.
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (mem_wr_addr !== 32'(32'h100 * (i + 1))) begin n_fail++; $display("FAIL ovf_drain_%0d: got %h want %h", i, mem_wr_addr, 32'h100 * (i + 1)); end
            set_in(0, '0, '0, '0, 1, 0, '0, '0);
            tick();
        end
        n_checks++; if (wr_fifo_empty !== 1'b1) begin n_fail++; $display("FAIL ovf_drain_empty: got %0b want 1", wr_fifo_empty); end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_in(1, 32'h100 * (i + 1), 64'(i + 1), 2'd3, 0, 0, '0, '0);
            tick();
        end
        set_in(1, 32'h500, 64'h5, 2'd1, 1, 0, '0, '0);
        tick();
        n_checks++; if (wr_fifo_ovf !== 1'b0) begin n_fail++; $display("FAIL pp_ovf: got %0b want 0", wr_fifo_ovf); end
        n_checks++; if (mem_wr_addr !== 32'h200) begin n_fail++; $display("FAIL pp_head: got %h want 200", mem_wr_addr); end
        n_checks++; if (wr_fifo_to_be_full !== 1'b1) begin n_fail++; $display("FAIL pp_tbf: got %0b want 1", wr_fifo_to_be_full); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (mem_wr_addr !== 32'(32'h100 * (i + 2))) begin n_fail++; $display("FAIL pp_drain_%0d: got %h want %h", i, mem_wr_addr, 32'h100 * (i + 2)); end
            set_in(0, '0, '0, '0, 1, 0, '0, '0);
            tick();
        end
        n_checks++; if (wr_fifo_empty !== 1'b1) begin n_fail++; $display("FAIL pp_empty: got %0b want 1", wr_fifo_empty); end
    endtask

    task automatic test_conflict();
        do_reset();
        set_in(1, 32'h200C, 64'h1, 2'd3, 0, 0, '0, '0);
        tick();
        set_in(0, '0, '0, '0, 0, 1, 32'h2010, 2'd0);
        #1;
        n_checks++; if (mem_conflict !== 1'b1) begin n_fail++; $display("FAIL conf_straddle: got %0b want 1", mem_conflict); end
        ro_rd_addr = 32'h2020;
        #1;
        n_checks++; if (mem_conflict !== 1'b0) begin n_fail++; $display("FAIL conf_miss: got %0b want 0", mem_conflict); end
        v_mem_read = 1'b0; ro_rd_addr = 32'h2008;
        #1;
        n_checks++; if (mem_conflict !== 1'b0) begin n_fail++; $display("FAIL conf_no_vrd: got %0b want 0", mem_conflict); end
        // Entry being popped this cycle still counts.
        set_in(0, '0, '0, '0, 1, 1, 32'h2000, 2'd0);
        #1;
        n_checks++; if (mem_conflict !== 1'b1) begin n_fail++; $display("FAIL conf_popping: got %0b want 1", mem_conflict); end
        tick();
        // Wrapping store: 0xFFFFFFFF size 1 touches line 0.
        set_in(1, 32'hFFFF_FFFF, 64'h2, 2'd1, 0, 0, '0, '0);
        tick();
        set_in(0, '0, '0, '0, 0, 1, 32'h0000_0008, 2'd0);
        #1;
        n_checks++; if (mem_conflict !== 1'b1) begin n_fail++; $display("FAIL conf_wrap: got %0b want 1", mem_conflict); end
        set_in(0, '0, '0, '0, 0, 0, '0, '0);
    endtask

    task automatic test_incoming();
        do_reset();
        set_in(1, 32'h3000, 64'h3, 2'd2, 0, 1, 32'h3004, 2'd2);
        #1;
        n_checks++; if (mem_conflict !== 1'b1) begin n_fail++; $display("FAIL conf_incoming: got %0b want 1", mem_conflict); end
        tick();
        set_in(0, '0, '0, '0, 1, 0, '0, '0);
        tick();
        set_in(0, '0, '0, '0, 1, 0, '0, '0);
        tick();
        n_checks++; if (wr_fifo_empty !== 1'b1) begin n_fail++; $display("FAIL pop_on_empty: got %0b want 1", wr_fifo_empty); end
        set_in(1, 32'h3100, 64'h31, 2'd1, 0, 0, '0, '0);
        tick();
        n_checks++; if (mem_wr_addr !== 32'h3100 || mem_wr_data !== 64'h31) begin n_fail++; $display("FAIL pop_on_empty_ptr: got %h/%h want 3100/31", mem_wr_addr, mem_wr_data); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_in(1, 32'h6000, 64'h6, 2'd0, 0, 0, '0, '0);
        tick();
        set_in(1, 32'h6010, 64'h7, 2'd0, 0, 0, '0, '0);
        tick();
        set_in(0, '0, '0, '0, 0, 1, 32'h6000, 2'd0);
        #2;
        rst_n = 1'b0;
        q.delete();
        m_ovf = 0;
        #1;
        n_checks++; if (wr_fifo_empty !== 1'b1) begin n_fail++; $display("FAIL mid_rst_empty: got %0b want 1", wr_fifo_empty); end
        n_checks++; if ({mem_wr_addr, mem_wr_data, mem_wr_size} !== 98'd0) begin n_fail++; $display("FAIL mid_rst_head: got %h/%h/%0d want 0", mem_wr_addr, mem_wr_data, mem_wr_size); end
        n_checks++; if (mem_conflict !== 1'b0) begin n_fail++; $display("FAIL mid_rst_conflict: got %0b want 0", mem_conflict); end
        set_in(0, '0, '0, '0, 0, 0, '0, '0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [31:0] a, ra;
        bit exp_c;
        ent_t h;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            a  = 32'h4000 | 32'($urandom_range(0, 63));
            ra = 32'h4000 | 32'($urandom_range(0, 95));
            if ($urandom_range(0, 9) == 0) a  = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) ra = 32'($urandom_range(0, 15));
            set_in($urandom_range(0, 99) < 55, a, {$urandom, $urandom}, 2'($urandom_range(0, 3)),
                   $urandom_range(0, 99) < 45, $urandom_range(0, 1) == 1, ra, 2'($urandom_range(0, 3)));
            #1;
            exp_c = model_conflict();
            h = (q.size() > 0) ? q[0] : '{addr: '0, data: '0, size: '0};
            n_checks++; if (mem_conflict !== exp_c) begin n_fail++; $display("FAIL rnd_conflict@%0d: got %0b want %0b", cyc, mem_conflict, exp_c); end
            n_checks++; if ({mem_wr_addr, mem_wr_data, mem_wr_size} !== {h.addr, h.data, h.size}) begin n_fail++; $display("FAIL rnd_head@%0d: got %h/%h/%0d want %h/%h/%0d", cyc, mem_wr_addr, mem_wr_data, mem_wr_size, h.addr, h.data, h.size); end
            n_checks++; if (wr_fifo_empty !== (q.size() == 0)) begin n_fail++; $display("FAIL rnd_empty@%0d: got %0b want %0b", cyc, wr_fifo_empty, q.size() == 0); end
            n_checks++; if (wr_fifo_to_be_full !== (q.size() >= DEPTH - 1)) begin n_fail++; $display("FAIL rnd_tbf@%0d: got %0b want %0b", cyc, wr_fifo_to_be_full, q.size() >= DEPTH - 1); end
            n_checks++; if (wr_fifo_ovf !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf@%0d: got %0b want %0b", cyc, wr_fifo_ovf, m_ovf); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_first_push();
        test_fill_ovf();
        test_full_push_pop();
        test_conflict();
        test_incoming();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
